// File: rtl/uart_rx_frame_checker.sv
// uart_rx_frame_checker
// Takes one sampled UART bit per bit_vld strobe after the start bit. Rebuilds
// the data word LSB-first, checks parity (even/odd/mark/space) and one or two
// stop bits, then delivers the word with per-frame error flags. Also keeps
// sticky error flags and saturating error counters for the register block.
//
// state  | meaning
// IDLE   | waiting for frame_start; bit_vld ignored
// DATA   | shifting in DATA_WIDTH data bits
// PARITY | waiting for the parity bit
// STOP_1 | waiting for the first stop bit
// STOP_2 | waiting for the second stop bit (STOP2 frames only)
// DONE   | one-cycle delivery; status and counters update here

module uart_rx_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  frame_start,
    input  logic                  bit_vld,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  STOP2,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_vld,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  par_err_sticky,
    output logic                  stp_err_sticky,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt,
    output logic                  busy
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP_1 = 3'd3;
    localparam logic [2:0] ST_STOP_2 = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [1:0] PT_EVEN  = 2'b00;
    localparam logic [1:0] PT_ODD   = 2'b01;
    localparam logic [1:0] PT_MARK  = 2'b10;
    localparam logic [1:0] PT_SPACE = 2'b11;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  par_acc_q, par_acc_d;
    logic                  cfg_par_en_q, cfg_par_en_d;
    logic [1:0]            cfg_par_typ_q, cfg_par_typ_d;
    logic                  cfg_stop2_q, cfg_stop2_d;
    logic                  frame_par_err_q, frame_par_err_d;
    logic                  frame_stp_err_q, frame_stp_err_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_vld_q, data_vld_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  par_sticky_q, par_sticky_d;
    logic                  stp_sticky_q, stp_sticky_d;
    logic [CNT_WIDTH-1:0]  par_cnt_q, par_cnt_d;
    logic [CNT_WIDTH-1:0]  stp_cnt_q, stp_cnt_d;

    logic                  deliver;
    logic                  exp_par;
    logic [CNT_WIDTH-1:0]  par_base;
    logic [CNT_WIDTH-1:0]  stp_base;
    logic                  in_done;

    // Expected parity bit from the captured mode and the running XOR of data.
    always_comb begin
        exp_par = 1'b0;
        case (cfg_par_typ_q)
            PT_EVEN:  exp_par = par_acc_q;
            PT_ODD:   exp_par = ~par_acc_q;
            PT_MARK:  exp_par = 1'b1;
            PT_SPACE: exp_par = 1'b0;
            default:  exp_par = 1'b0;
        endcase
    end

    // Frame sequencing: next state, data shift, parity and stop-bit checks.
    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        par_acc_d       = par_acc_q;
        cfg_par_en_d    = cfg_par_en_q;
        cfg_par_typ_d   = cfg_par_typ_q;
        cfg_stop2_d     = cfg_stop2_q;
        frame_par_err_d = frame_par_err_q;
        frame_stp_err_d = frame_stp_err_q;
        deliver         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d         = ST_DATA;
                    bit_cnt_d       = '0;
                    par_acc_d       = 1'b0;
                    frame_par_err_d = 1'b0;
                    frame_stp_err_d = 1'b0;
                    cfg_par_en_d    = PAR_EN;
                    cfg_par_typ_d   = PAR_TYP;
                    cfg_stop2_d     = STOP2;
                end
            end
            ST_DATA: begin
                if (bit_vld) begin
                    shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    par_acc_d = par_acc_q ^ sampled_bit;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = cfg_par_en_q ? ST_PARITY : ST_STOP_1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_vld) begin
                    frame_par_err_d = (sampled_bit != exp_par);
                    state_d         = ST_STOP_1;
                end
            end
            ST_STOP_1: begin
                if (bit_vld) begin
                    frame_stp_err_d = ~sampled_bit;
                    if (cfg_stop2_q) begin
                        state_d = ST_STOP_2;
                    end else begin
                        state_d = ST_DONE;
                        deliver = 1'b1;
                    end
                end
            end
            ST_STOP_2: begin
                if (bit_vld) begin
                    frame_stp_err_d = frame_stp_err_q | ~sampled_bit;
                    state_d         = ST_DONE;
                    deliver         = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output word and frame flags load on the last stop strobe so they are
    // already valid in the DONE cycle alongside data_vld.
    always_comb begin
        p_data_d   = p_data_q;
        par_err_d  = par_err_q;
        stp_err_d  = stp_err_q;
        data_vld_d = deliver;
        if (deliver) begin
            p_data_d  = shift_q;
            par_err_d = frame_par_err_q;
            stp_err_d = frame_stp_err_d;
        end
    end

    // Sticky flags and saturating counters; a clear in the DONE cycle still
    // lets that frame's error land on top of the cleared value.
    always_comb begin
        in_done  = (state_q == ST_DONE);
        par_base = err_clr ? '0 : par_cnt_q;
        stp_base = err_clr ? '0 : stp_cnt_q;

        par_cnt_d = par_base;
        if (in_done && par_err_q && (par_base != CNT_MAX)) begin
            par_cnt_d = par_base + CNT_WIDTH'(1);
        end
        stp_cnt_d = stp_base;
        if (in_done && stp_err_q && (stp_base != CNT_MAX)) begin
            stp_cnt_d = stp_base + CNT_WIDTH'(1);
        end

        par_sticky_d = (err_clr ? 1'b0 : par_sticky_q) | (in_done & par_err_q);
        stp_sticky_d = (err_clr ? 1'b0 : stp_sticky_q) | (in_done & stp_err_q);
    end

    // State registers; reset aborts any frame in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= ST_IDLE;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            par_acc_q       <= 1'b0;
            cfg_par_en_q    <= 1'b0;
            cfg_par_typ_q   <= 2'b00;
            cfg_stop2_q     <= 1'b0;
            frame_par_err_q <= 1'b0;
            frame_stp_err_q <= 1'b0;
            p_data_q        <= '0;
            data_vld_q      <= 1'b0;
            par_err_q       <= 1'b0;
            stp_err_q       <= 1'b0;
            par_sticky_q    <= 1'b0;
            stp_sticky_q    <= 1'b0;
            par_cnt_q       <= '0;
            stp_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            par_acc_q       <= par_acc_d;
            cfg_par_en_q    <= cfg_par_en_d;
            cfg_par_typ_q   <= cfg_par_typ_d;
            cfg_stop2_q     <= cfg_stop2_d;
            frame_par_err_q <= frame_par_err_d;
            frame_stp_err_q <= frame_stp_err_d;
            p_data_q        <= p_data_d;
            data_vld_q      <= data_vld_d;
            par_err_q       <= par_err_d;
            stp_err_q       <= stp_err_d;
            par_sticky_q    <= par_sticky_d;
            stp_sticky_q    <= stp_sticky_d;
            par_cnt_q       <= par_cnt_d;
            stp_cnt_q       <= stp_cnt_d;
        end
    end

    assign P_DATA         = p_data_q;
    assign data_vld       = data_vld_q;
    assign par_err        = par_err_q;
    assign stp_err        = stp_err_q;
    assign par_err_sticky = par_sticky_q;
    assign stp_err_sticky = stp_sticky_q;
    assign par_err_cnt    = par_cnt_q;
    assign stp_err_cnt    = stp_cnt_q;
    assign busy           = (state_q != ST_IDLE);

endmodule
